instr_mem_pipe: RTL and testbench

INSTR_MEM_PIPE -- requirements
Module: instr_mem_pipe

---
 rtl/instr_mem_pipe_pkg.sv | 41 ++++
 rtl/mem_lane_align.sv | 55 +++++
 rtl/instr_mem_pipe.sv | 208 ++++++++++++++++++++
 tb/tb_instr_mem_pipe.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pipe_pkg.sv
// rtl/instr_mem_pipe_pkg.sv - shared encodings and helpers for the instruction/data memory
//
// Holds the data-port access size encodings, the data FSM state encodings,
// the default fetch value for invalid addresses, and small size helpers.
package instr_mem_pipe_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } d_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SPLIT = 2'b01,
        ST_RESP  = 2'b10
    } d_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // Number of bytes touched by an access; the illegal size reports 4 so the
    // crossing logic stays well-defined (the access is rejected anyway).
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_bytes = 3'd1;
            SIZE_HALF: size_bytes = 3'd2;
            default:   size_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_mask = 4'b0001;
            SIZE_HALF: size_mask = 4'b0011;
            default:   size_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - combinational byte-lane alignment for the data port
//
// Ports:
//   offset_i, size_i, unsigned_i : byte offset in the first word, access size, zero-extend
//   wdata_i                      : LSB-aligned store data
//   rword0_i, rword1_i           : first and second memory word (second only used when crossing)
//   cross_o                      : access spills into the next word
//   wmask0_o/wdata0_o            : byte enables and data for the first word
//   wmask1_o/wdata1_o            : byte enables and data for the second word
//   rdata_o                      : extracted and extended load data
module mem_lane_align
    import instr_mem_pipe_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword0_i,
    input  logic [31:0] rword1_i,
    output logic        cross_o,
    output logic [3:0]  wmask0_o,
    output logic [3:0]  wmask1_o,
    output logic [31:0] wdata0_o,
    output logic [31:0] wdata1_o,
    output logic [31:0] rdata_o
);

    logic [5:0]  shamt;
    logic [31:0] raw;
    logic [7:0]  lane_mask;
    logic [63:0] wide_wdata;

    assign shamt = {offset_i, 3'b000};

    // Both words are viewed as one little-endian 64-bit window so crossing
    // and non-crossing accesses share the same shift.
    always_comb begin
        raw        = 32'({rword1_i, rword0_i} >> shamt);
        lane_mask  = {4'b0000, size_mask(size_i)} << offset_i;
        wide_wdata = {32'h0, wdata_i} << shamt;
        cross_o    = ({1'b0, offset_i} + size_bytes(size_i)) > 3'd4;
        case (size_i)
            SIZE_BYTE: rdata_o = unsigned_i ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            SIZE_HALF: rdata_o = unsigned_i ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            SIZE_WORD: rdata_o = raw;
            default:   rdata_o = 32'h0;
        endcase
    end

    assign wmask0_o = lane_mask[3:0];
    assign wmask1_o = lane_mask[7:4];
    assign wdata0_o = wide_wdata[31:0];
    assign wdata1_o = wide_wdata[63:32];

endmodule

// File: rtl/instr_mem_pipe.sv
// rtl/instr_mem_pipe.sv - dual-port instruction fetch / data load-store memory
//
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   if_req, if_addr               : fetch request and byte address (accepted every cycle)
//   if_valid, if_instr            : registered fetch result, one cycle later
//   d_req, d_we, d_addr, d_size,
//   d_unsigned, d_wdata           : data request, accepted when d_req && d_ready
//   d_ready                       : data port idle
//   d_rvalid, d_rdata, d_err      : single-cycle completion with load data / error flag
module instr_mem_pipe
    import instr_mem_pipe_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          MEM_SIZE    = 1024,
    parameter int          MISALIGN_EN = 1,
    parameter logic [31:0] NOP_WORD    = NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_valid,
    output logic [31:0]           if_instr,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [1:0]            d_size,
    input  logic                  d_unsigned,
    input  logic [31:0]           d_wdata,
    output logic                  d_ready,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,
    output logic                  d_err
);

    localparam int IDX_W = $clog2(MEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] WORDS = ADDR_WIDTH'(MEM_SIZE);

    logic [31:0] mem_q [MEM_SIZE];

    d_state_e          state_q, state_d;
    logic [1:0]        off_q, size_q;
    logic              uns_q, we_q, err_q;
    logic [31:0]       wdata_q, word0_q, rdata_q;
    logic [IDX_W-1:0]  idx1_q;
    logic              if_valid_q;
    logic [31:0]       if_instr_q;

    // Word indices kept at full address width so the +1 of a crossing access
    // at the top of the address space cannot wrap back into range.
    logic [ADDR_WIDTH-1:0] d_word, d_word_next, if_word;
    logic [IDX_W-1:0]      idx0, if_idx;

    assign d_word      = {2'b00, d_addr[ADDR_WIDTH-1:2]};
    assign d_word_next = d_word + ADDR_WIDTH'(1);
    assign if_word     = {2'b00, if_addr[ADDR_WIDTH-1:2]};
    assign idx0        = d_addr[IDX_W+1:2];
    assign if_idx      = if_addr[IDX_W+1:2];

    // Alignment operates on the live request while idle and on the latched
    // request during SPLIT, so one instance serves both halves.
    logic        sel_lat;
    logic [1:0]  al_off, al_size;
    logic        al_uns, al_cross;
    logic [31:0] al_wdata, al_rword0, al_rword1, al_rdata, al_wdata0, al_wdata1;
    logic [3:0]  al_wmask0, al_wmask1;

    assign sel_lat   = (state_q != ST_IDLE);
    assign al_off    = sel_lat ? off_q   : d_addr[1:0];
    assign al_size   = sel_lat ? size_q  : d_size;
    assign al_uns    = sel_lat ? uns_q   : d_unsigned;
    assign al_wdata  = sel_lat ? wdata_q : d_wdata;
    assign al_rword0 = sel_lat ? word0_q : mem_q[idx0];
    assign al_rword1 = mem_q[idx1_q];

    mem_lane_align u_align (
        .offset_i   (al_off),
        .size_i     (al_size),
        .unsigned_i (al_uns),
        .wdata_i    (al_wdata),
        .rword0_i   (al_rword0),
        .rword1_i   (al_rword1),
        .cross_o    (al_cross),
        .wmask0_o   (al_wmask0),
        .wmask1_o   (al_wmask1),
        .wdata0_o   (al_wdata0),
        .wdata1_o   (al_wdata1),
        .rdata_o    (al_rdata)
    );

    logic acc_err;
    assign acc_err = (d_size == SIZE_ILLEGAL)
                   || (al_cross && (MISALIGN_EN == 0))
                   || (d_word >= WORDS)
                   || (al_cross && (d_word_next >= WORDS));

    logic             mem_we, lat_en, rsp_en, rsp_err;
    logic [IDX_W-1:0] mem_widx;
    logic [3:0]       mem_wmask;
    logic [31:0]      mem_wdata, rsp_data;

    always_comb begin
        state_d   = state_q;
        mem_we    = 1'b0;
        mem_widx  = idx0;
        mem_wmask = al_wmask0;
        mem_wdata = al_wdata0;
        lat_en    = 1'b0;
        rsp_en    = 1'b0;
        rsp_data  = 32'h0;
        rsp_err   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (d_req) begin
                    lat_en = 1'b1;
                    if (acc_err) begin
                        rsp_en  = 1'b1;
                        rsp_err = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        mem_we = d_we;
                        if (al_cross) begin
                            state_d = ST_SPLIT;
                        end else begin
                            rsp_en   = 1'b1;
                            rsp_data = d_we ? 32'h0 : al_rdata;
                            state_d  = ST_RESP;
                        end
                    end
                end
            end
            ST_SPLIT: begin
                mem_we    = we_q;
                mem_widx  = idx1_q;
                mem_wmask = al_wmask1;
                mem_wdata = al_wdata1;
                rsp_en    = 1'b1;
                rsp_data  = we_q ? 32'h0 : al_rdata;
                state_d   = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
            word0_q <= 32'h0;
            idx1_q  <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (lat_en) begin
                off_q   <= d_addr[1:0];
                size_q  <= d_size;
                uns_q   <= d_unsigned;
                we_q    <= d_we;
                wdata_q <= d_wdata;
                word0_q <= mem_q[idx0];
                idx1_q  <= idx0 + IDX_W'(1);
            end
            if (rsp_en) begin
                rdata_q <= rsp_data;
                err_q   <= rsp_err;
            end
        end
    end

    // Contents survive reset; writes are suppressed while reset is held so an
    // aborted SPLIT never completes its second half.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wmask[b]) mem_q[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // Nonblocking read of mem_q gives read-before-write against a same-cycle store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid_q <= 1'b0;
            if_instr_q <= 32'h0;
        end else begin
            if_valid_q <= if_req;
            if (if_req) begin
                if ((if_addr[1:0] != 2'b00) || (if_word >= WORDS)) if_instr_q <= NOP_WORD;
                else                                                if_instr_q <= mem_q[if_idx];
            end
        end
    end

    assign if_valid = if_valid_q;
    assign if_instr = if_instr_q;
    assign d_ready  = (state_q == ST_IDLE);
    assign d_rvalid = (state_q == ST_RESP);
    assign d_rdata  = d_rvalid ? rdata_q : 32'h0;
    assign d_err    = d_rvalid & err_q;

endmodule

// File: tb/tb_instr_mem_pipe.sv
// tb/tb_instr_mem_pipe.sv - self-checking bench for instr_mem_pipe against a byte-array model
module tb_instr_mem_pipe;

    localparam int MS = 16;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_valid;
    logic [31:0]   if_instr;
    logic          d_req = 1'b0, d_we = 1'b0, d_unsigned = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [1:0]    d_size = 2'b00;
    logic [31:0]   d_wdata = '0;
    logic          d_ready, d_rvalid, d_err;
    logic [31:0]   d_rdata;

    logic          m0_if_valid, m0_d_ready, m0_d_rvalid, m0_d_err;
    logic [31:0]   m0_if_instr, m0_d_rdata;
    logic          m0_rv_s, m0_err_s;
    logic [31:0]   m0_rd_s;

    always #5 clk = ~clk;

    instr_mem_pipe #(.ADDR_WIDTH(AW), .MEM_SIZE(MS), .MISALIGN_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr),
        .if_valid(if_valid), .if_instr(if_instr), .d_req(d_req), .d_we(d_we),
        .d_addr(d_addr), .d_size(d_size), .d_unsigned(d_unsigned), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err)
    );

    instr_mem_pipe #(.ADDR_WIDTH(AW), .MEM_SIZE(MS), .MISALIGN_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr),
        .if_valid(m0_if_valid), .if_instr(m0_if_instr), .d_req(d_req), .d_we(d_we),
        .d_addr(d_addr), .d_size(d_size), .d_unsigned(d_unsigned), .d_wdata(d_wdata),
        .d_ready(m0_d_ready), .d_rvalid(m0_d_rvalid), .d_rdata(m0_d_rdata), .d_err(m0_d_err)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] mm [0:4*MS-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nb(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_cross(input int a, input logic [1:0] s);
        return ((a % 4) + nb(s)) > 4;
    endfunction

    function automatic bit m_err(input int a, input logic [1:0] s);
        if (s == 2'd3) return 1'b1;
        if (a / 4 >= MS || (a + nb(s) - 1) / 4 >= MS) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input int a, input logic [1:0] s, input logic uns);
        int n = nb(s);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mm[a+i]) << (8*i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
        return v;
    endfunction

    function automatic logic [31:0] m_fetch(input int a);
        if (a % 4 != 0 || a / 4 >= MS) return 32'h00000013;
        return {mm[a+3], mm[a+2], mm[a+1], mm[a]};
    endfunction

    // One data transaction, optionally with a fetch in the accept cycle.
    task automatic dacc(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd, input logic fe,
                        input logic [31:0] fa, output logic [31:0] rd, output logic er,
                        output int lat, output logic [31:0] fi);
        @(negedge clk);
        chk("ready_idle", {31'b0, d_ready}, 32'd1);
        chk("rvalid_idle", {31'b0, d_rvalid}, 32'd0);
        d_req = 1'b1; d_we = we; d_addr = addr; d_size = sz; d_unsigned = uns; d_wdata = wd;
        if_req = fe; if_addr = fa;
        @(negedge clk);
        d_req = 1'b0; d_we = 1'($urandom); d_addr = $urandom; d_size = 2'($urandom);
        d_unsigned = 1'($urandom); d_wdata = $urandom;
        fi = if_instr; if_req = 1'b0;
        m0_rv_s = m0_d_rvalid; m0_err_s = m0_d_err; m0_rd_s = m0_d_rdata;
        lat = 1;
        while (!d_rvalid && lat < 6) begin
            chk("ready_busy", {31'b0, d_ready}, 32'd0);
            @(negedge clk);
            lat++;
        end
        chk("ready_busy", {31'b0, d_ready}, 32'd0);
        rd = d_rdata; er = d_err;
    endtask

    logic [31:0] last_rd, last_fi;
    logic        last_er;

    task automatic acc(input logic we, input int addr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] wd, input logic fe, input int fa);
        logic exp_err = m_err(addr, sz);
        int exp_lat = exp_err ? 1 : (m_cross(addr, sz) ? 2 : 1);
        logic [31:0] exp_rd = (exp_err || we) ? 32'h0 : m_load(addr, sz, uns);
        logic [31:0] exp_f = m_fetch(fa);
        int lat;
        dacc(we, 32'(addr), sz, uns, wd, fe, 32'(fa), last_rd, last_er, lat, last_fi);
        chk("d_rdata", last_rd, exp_rd);
        chk("d_err", {31'b0, last_er}, {31'b0, exp_err});
        chk("latency", 32'(lat), 32'(exp_lat));
        if (fe) chk("fetch_rbw", last_fi, exp_f);
        if (!exp_err && we)
            for (int i = 0; i < nb(sz); i++) mm[addr+i] = 8'(wd >> (8*i));
    endtask

    task automatic fetch_chk(input int a);
        logic [31:0] exp = m_fetch(a);
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'(a);
        @(negedge clk);
        chk("if_valid", {31'b0, if_valid}, 32'd1);
        chk("if_instr", if_instr, exp);
        if_req = 1'b0; if_addr = $urandom;
        @(negedge clk);
        chk("if_valid_low", {31'b0, if_valid}, 32'd0);
        chk("if_instr_hold", if_instr, exp);
    endtask

    logic [31:0] w1_before;

    initial begin
        for (int i = 0; i < 4*MS; i++) mm[i] = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_rvalid", {31'b0, d_rvalid}, 32'd0);
        chk("rst_rdata", d_rdata, 32'd0);
        chk("rst_err", {31'b0, d_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'b0, d_ready}, 32'd1);

        for (int i = 0; i < MS; i++) acc(1'b1, 4*i, 2'd2, 1'b0, $urandom, 1'b0, 0);
        acc(1'b1, 0, 2'd2, 1'b0, 32'h8899AABB, 1'b0, 0);
        acc(1'b1, 4, 2'd2, 1'b0, 32'h11223344, 1'b0, 0);

        acc(1'b0, 1, 2'd0, 1'b0, 32'h0, 1'b0, 0);
        chk("lb_signed", last_rd, 32'hFFFFFFAA);
        acc(1'b0, 1, 2'd0, 1'b1, 32'h0, 1'b0, 0);
        chk("lbu", last_rd, 32'h000000AA);
        acc(1'b0, 3, 2'd2, 1'b0, 32'h0, 1'b0, 0);
        chk("lw_cross", last_rd, 32'h22334488);
        acc(1'b0, 3, 2'd1, 1'b0, 32'h0, 1'b0, 0);
        chk("m0_rvalid", {31'b0, m0_rv_s}, 32'd1);
        chk("m0_err", {31'b0, m0_err_s}, 32'd1);
        chk("m0_rdata", m0_rd_s, 32'd0);

        acc(1'b1, 3, 2'd1, 1'b0, 32'h0000BEEF, 1'b0, 0);
        acc(1'b0, 0, 2'd2, 1'b0, 32'h0, 1'b0, 0);
        chk("sh_word0", last_rd, 32'hEF99AABB);
        acc(1'b0, 4, 2'd2, 1'b0, 32'h0, 1'b0, 0);
        chk("sh_word1", last_rd, 32'h112233BE);
        acc(1'b0, 4*MS, 2'd2, 1'b0, 32'h0, 1'b0, 0);
        chk("lw_oob_err", {31'b0, last_er}, 32'd1);
        acc(1'b0, 0, 2'd3, 1'b0, 32'h0, 1'b0, 0);
        chk("size11_err", {31'b0, last_er}, 32'd1);

        fetch_chk(2);
        fetch_chk(4*MS);
        fetch_chk(4);
        acc(1'b1, 0, 2'd2, 1'b0, 32'h12345678, 1'b1, 0);
        chk("fetch_old", last_fi, 32'hEF99AABB);
        fetch_chk(0);

        for (int t = 0; t < 300; t++) begin
            logic [1:0] sz = 2'($urandom_range(0, 3));
            int a = int'($urandom_range(0, 4*MS + 7));
            int fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4*MS + 7))
                                                 : 4 * int'($urandom_range(0, MS));
            acc(1'($urandom), a, sz, 1'($urandom), $urandom, 1'($urandom), fa);
        end

        w1_before = {mm[7], mm[6], mm[5], mm[4]};
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'd2; d_size = 2'd2; d_unsigned = 1'b0;
        d_wdata = 32'hCAFEF00D;
        @(negedge clk);
        d_req = 1'b0;
        chk("split_busy", {31'b0, d_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'b0, d_ready}, 32'd1);
        chk("abort_rvalid", {31'b0, d_rvalid}, 32'd0);
        chk("abort_if_valid", {31'b0, if_valid}, 32'd0);
        @(negedge clk);
        chk("abort_rvalid2", {31'b0, d_rvalid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_rvalid3", {31'b0, d_rvalid}, 32'd0);
        chk("abort_ready2", {31'b0, d_ready}, 32'd1);
        mm[2] = 8'h0D;
        mm[3] = 8'hF0;
        acc(1'b0, 0, 2'd2, 1'b0, 32'h0, 1'b0, 0);
        chk("abort_word0_hi", {16'h0, last_rd[31:16]}, 32'h0000F00D);
        acc(1'b0, 4, 2'd2, 1'b0, 32'h0, 1'b0, 0);
        chk("abort_word1", last_rd, w1_before);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
